alu_ctrl_mdu: RTL and testbench
===============================

# alu_ctrl_mdu

Parametrised ALU control unit for the single-cycle/multi-cycle MIPS datapath, with an integrated iterative multiply/divide unit (MDU) and HI/LO registers. Decodes the main controller's `alu_op` and the instruction `funct` field into a 4-bit ALU operation code. It also runs multi-cycle `mult`/`multu`/`div`/`divu` and issues a stall to the pipeline/controller while the MDU is busy. It sits between the main control unit and the ALU, in parallel with the ALU operand path.

## Interface
- `WIDTH`, 32: datapath width; the MDU iterates `WIDTH` times.
- `CTRL_W`, 4: ALU control code width; fixed at 4.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: synchronous, active-low reset.
- `alu_op` input 2: 00 = add, 01 = sub, 10 = R-type (decode `funct`), 11 = or (ori).
- `funct` input 6: instruction `funct` field.
- `valid` input 1: the current instruction is real; MDU side effects are gated by it.
- `a`, `b` input WIDTH: rs/rt operands for MDU and `mthi`/`mtlo`.
- `ctrl` output CTRL_W: combinational ALU operation code.
- `illegal` output 1: combinational; R-type with an unrecognised `funct`.
- `hi`, `lo` output WIDTH: architectural HI/LO registers.
- `md_busy` output 1: MDU operation in flight.
- `md_done` output 1: one-cycle pulse when HI/LO have just been updated by the MDU.
- `stall` output 1: combinational; the controller must hold the instruction.

## Operation
- ALU codes: and 0000, or 0001, add 0010, xor 0011, sub 0110, slt 0111, sll 1000, srl 1001, nor 1100.
- `alu_op` 00 → 0010; 01 → 0110; 11 → 0001.
- `alu_op` 10, `funct` mapping:
  - 100000/100001 → add
  - 100010/100011 → sub
  - 100100 → and; 100101 → or; 100110 → xor; 100111 → nor
  - 101010 → slt; 000000 → sll; 000010 → srl
- MDU `funct` codes: mult 011000, multu 011001, div 011010, divu 011011, mfhi 010000, mthi 010001, mflo 010010, mtlo 010011.
  - These are legal and set `ctrl` = 0010.
- Any other `funct` with `alu_op` 10: `ctrl` = 0000, `illegal` = 1.
- MDU FSM: IDLE → RUN → FIX → IDLE.
  - IDLE: a mult/div with `valid` is accepted at the edge. Operands are latched; for signed ops they are latched as magnitudes plus sign flags. Next state RUN, counter = 0.
  - RUN: one radix-2 step per cycle (shift-add for multiply, restoring shift-subtract for divide). After `WIDTH` steps, go to FIX.
  - FIX: apply sign correction; HI/LO are written at the edge leaving FIX; go to IDLE; `md_done` is registered high for the next cycle.
- Results:
  - Multiply: HI:LO = full 2·WIDTH-bit product.
  - Divide: LO = quotient, HI = remainder. The quotient truncates toward zero; the remainder takes the dividend's sign.
- Divide by zero: the RUN steps are skipped (IDLE → FIX directly); HI = `a`, LO = all ones.
- `mthi`/`mtlo` with `valid` while idle: HI/LO written at the edge. `mfhi`/`mflo` need no state change; the datapath reads `hi`/`lo`.
- `stall` = `valid` and (mult/div/mthi/mtlo/mfhi/mflo) and (`md_busy` or FSM not IDLE).
  - A stalled instruction has no side effect; the controller re-presents it.

## Timing
- Reset values: `hi` = 0, `lo` = 0, `md_busy` = 0, `md_done` = 0, FSM = IDLE, counter = 0.
- Acceptance at edge E0. `md_busy` is high from after E0 through the FIX cycle.
- HI/LO are updated at edge E0+WIDTH+1. `md_done` is high in the cycle after E0+WIDTH+1.
- Divide by zero: HI/LO are updated at E0+1; `md_done` is high in the cycle after E0+1.
- A new mult/div in the same cycle as `md_done` is accepted (FSM is IDLE); HI/LO are not corrupted.
- `rst_n` low during RUN/FIX: the operation is aborted at that edge and every output returns to its reset value; no `md_done`.
- `ctrl` and `illegal` have zero latency and are independent of MDU state.

## Configuration
- `ALU_CTRL_DIV_EN` defined: div/divu are supported as above.
- `ALU_CTRL_DIV_EN` undefined:
  - The divide datapath is not compiled.
  - `funct` 011010/011011 decode as illegal (`illegal` = 1, `ctrl` = 0000).
  - No MDU start; no stall.

## Structure
- Package `alu_ctrl_pkg` holds:
  - ALU code localparams.
  - `funct` constants.
  - `alu_op` encodings.
  - The FSM state typedef (IDLE/RUN/FIX).
- Sub-module `mdu_core`: the iterative engine, containing:
  - operand and partial registers
  - counter
  - sign fix
- The top level does decode, stall, start gating and the HI/LO registers.

## Test plan
- Decode: `alu_op` 01 → `ctrl` 0110. `alu_op` 10 with `funct` 101010 → 0111, `illegal` 0. `funct` 111111 → 0000, `illegal` 1.
- Signed mult, `a` = 0xFFFFFFFE, `b` = 3 → after 33 edges HI = 0xFFFFFFFF, LO = 0xFFFFFFFA, one `md_done` pulse.
- multu with the same operands → HI = 0x00000002, LO = 0xFFFFFFFA.
- Signed div, `a` = 0xFFFFFFF9 (−7), `b` = 2 → LO = 0xFFFFFFFD, HI = 0xFFFFFFFF.
- div with `b` = 0, `a` = 0x1234 → HI = 0x1234, LO = 0xFFFFFFFF, `md_done` two cycles after acceptance.
- mflo while busy → `stall` held until FSM returns to IDLE.
- `rst_n` low at RUN step 10 → `hi` = `lo` = 0, `md_busy` = 0, no `md_done`.

Source files
------------

// File: rtl/alu_ctrl_pkg.sv
// Shared constants for the ALU control / MDU slice: ALU codes, funct codes,
// alu_op encodings and the MDU state and operation types.
package alu_ctrl_pkg;

    // ALU operation codes
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_XOR = 4'b0011;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_SLL = 4'b1000;
    localparam logic [3:0] ALU_SRL = 4'b1001;
    localparam logic [3:0] ALU_NOR = 4'b1100;

    // alu_op encodings from the main controller
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;
    localparam logic [1:0] ALUOP_OR    = 2'b11;

    // R-type funct codes
    localparam logic [5:0] F_ADD   = 6'b100000;
    localparam logic [5:0] F_ADDU  = 6'b100001;
    localparam logic [5:0] F_SUB   = 6'b100010;
    localparam logic [5:0] F_SUBU  = 6'b100011;
    localparam logic [5:0] F_AND   = 6'b100100;
    localparam logic [5:0] F_OR    = 6'b100101;
    localparam logic [5:0] F_XOR   = 6'b100110;
    localparam logic [5:0] F_NOR   = 6'b100111;
    localparam logic [5:0] F_SLT   = 6'b101010;
    localparam logic [5:0] F_SLL   = 6'b000000;
    localparam logic [5:0] F_SRL   = 6'b000010;
    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MTHI  = 6'b010001;
    localparam logic [5:0] F_MFLO  = 6'b010010;
    localparam logic [5:0] F_MTLO  = 6'b010011;
    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_RUN  = 2'd1,
        MD_FIX  = 2'd2
    } md_state_t;

    typedef enum logic [1:0] {
        MD_MULT  = 2'd0,
        MD_MULTU = 2'd1,
        MD_DIV   = 2'd2,
        MD_DIVU  = 2'd3
    } md_op_t;

endpackage

// File: rtl/alu_ctrl_mdu_core.sv
// mdu_core: iterative radix-2 multiply/divide engine. Signed operands are
// held as magnitudes with sign flags; the sign is applied in the FIX state.
// Divide datapath present only when ALU_CTRL_DIV_EN is defined.
module mdu_core
    import alu_ctrl_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  md_op_t           op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             wr_en,
    output logic [WIDTH-1:0] res_hi,
    output logic [WIDTH-1:0] res_lo
);

    localparam int CW = $clog2(WIDTH + 1);

    md_state_t          state;
    logic [CW-1:0]      cnt;
    logic [WIDTH-1:0]   opa;        // multiplicand or divisor magnitude
    logic [2*WIDTH-1:0] acc;        // product, or {remainder, quotient}
    logic               neg_q;      // negate product / quotient
    logic               neg_r;      // negate remainder
    logic               div_mode;

    logic               op_signed;
    logic               sa, sb;
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] step_next;
    logic [2*WIDTH-1:0] prod_neg;

    assign op_signed = (op == MD_MULT) || (op == MD_DIV);
    assign sa        = op_signed & a[WIDTH-1];
    assign sb        = op_signed & b[WIDTH-1];
    assign mag_a     = sa ? ({WIDTH{1'b0}} - a) : a;
    assign mag_b     = sb ? ({WIDTH{1'b0}} - b) : b;

`ifdef ALU_CTRL_DIV_EN
    logic [WIDTH:0] div_t;
    logic           div_ge;
    logic [WIDTH:0] div_r;
`endif

    // one radix-2 step: shift-add for multiply, restoring shift-subtract for divide
    always_comb begin
        mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? opa : {WIDTH{1'b0}})};
        step_next = {mul_sum, acc[WIDTH-1:1]};
`ifdef ALU_CTRL_DIV_EN
        div_t  = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        div_ge = (div_t >= {1'b0, opa});
        div_r  = div_ge ? (div_t - {1'b0, opa}) : div_t;
        if (div_mode)
            step_next = {div_r[WIDTH-1:0], acc[WIDTH-2:0], div_ge};
`endif
    end

    // sign correction applied while in FIX
    always_comb begin
        prod_neg = {(2*WIDTH){1'b0}} - acc;
        if (div_mode) begin
            res_lo = neg_q ? ({WIDTH{1'b0}} - acc[WIDTH-1:0]) : acc[WIDTH-1:0];
            res_hi = neg_r ? ({WIDTH{1'b0}} - acc[2*WIDTH-1:WIDTH]) : acc[2*WIDTH-1:WIDTH];
        end else begin
            res_lo = neg_q ? prod_neg[WIDTH-1:0] : acc[WIDTH-1:0];
            res_hi = neg_q ? prod_neg[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
        end
    end

    assign busy  = (state != MD_IDLE);
    assign wr_en = (state == MD_FIX);

    // MDU sequencer: IDLE -> RUN (WIDTH steps) -> FIX -> IDLE
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= MD_IDLE;
            cnt      <= '0;
            opa      <= '0;
            acc      <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            div_mode <= 1'b0;
        end else begin
            case (state)
                MD_IDLE: begin
                    if (start) begin
                        cnt      <= '0;
                        state    <= MD_RUN;
                        div_mode <= 1'b0;
                        neg_q    <= sa ^ sb;
                        neg_r    <= 1'b0;
                        opa      <= mag_a;
                        acc      <= {{WIDTH{1'b0}}, mag_b};
`ifdef ALU_CTRL_DIV_EN
                        if (op == MD_DIV || op == MD_DIVU) begin
                            div_mode <= 1'b1;
                            if (b == '0) begin
                                // divide by zero: skip iteration, HI = a, LO = all ones
                                acc   <= {a, {WIDTH{1'b1}}};
                                neg_q <= 1'b0;
                                state <= MD_FIX;
                            end else begin
                                opa   <= mag_b;
                                acc   <= {{WIDTH{1'b0}}, mag_a};
                                neg_r <= sa;
                            end
                        end
`endif
                    end
                end
                MD_RUN: begin
                    acc <= step_next;
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(WIDTH - 1))
                        state <= MD_FIX;
                end
                MD_FIX: begin
                    state <= MD_IDLE;
                    cnt   <= '0;
                end
                default: state <= MD_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/alu_ctrl_mdu.sv
// alu_ctrl_mdu: ALU control decode plus HI/LO registers and start/stall
// gating for the iterative MDU. Define ALU_CTRL_DIV_EN to enable div/divu.
module alu_ctrl_mdu
    import alu_ctrl_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int CTRL_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        alu_op,
    input  logic [5:0]        funct,
    input  logic              valid,
    input  logic [WIDTH-1:0]  a,
    input  logic [WIDTH-1:0]  b,
    output logic [CTRL_W-1:0] ctrl,
    output logic              illegal,
    output logic [WIDTH-1:0]  hi,
    output logic [WIDTH-1:0]  lo,
    output logic              md_busy,
    output logic              md_done,
    output logic              stall
);

    logic [3:0]       code;
    logic             md_fam;    // any instruction that touches HI/LO or the MDU
    logic             md_go;     // mult/div family
    logic             is_mthi, is_mtlo;
    md_op_t           md_op;
    logic             wr_en;
    logic [WIDTH-1:0] res_hi, res_lo;
    logic             start;

    // alu_op / funct decode, independent of MDU state
    always_comb begin
        code    = ALU_AND;
        illegal = 1'b0;
        md_fam  = 1'b0;
        md_go   = 1'b0;
        is_mthi = 1'b0;
        is_mtlo = 1'b0;
        md_op   = MD_MULT;
        case (alu_op)
            ALUOP_ADD: code = ALU_ADD;
            ALUOP_SUB: code = ALU_SUB;
            ALUOP_OR:  code = ALU_OR;
            default: begin
                case (funct)
                    F_ADD, F_ADDU: code = ALU_ADD;
                    F_SUB, F_SUBU: code = ALU_SUB;
                    F_AND:         code = ALU_AND;
                    F_OR:          code = ALU_OR;
                    F_XOR:         code = ALU_XOR;
                    F_NOR:         code = ALU_NOR;
                    F_SLT:         code = ALU_SLT;
                    F_SLL:         code = ALU_SLL;
                    F_SRL:         code = ALU_SRL;
                    F_MFHI, F_MFLO: begin
                        code   = ALU_ADD;
                        md_fam = 1'b1;
                    end
                    F_MTHI: begin
                        code    = ALU_ADD;
                        md_fam  = 1'b1;
                        is_mthi = 1'b1;
                    end
                    F_MTLO: begin
                        code    = ALU_ADD;
                        md_fam  = 1'b1;
                        is_mtlo = 1'b1;
                    end
                    F_MULT, F_MULTU: begin
                        code   = ALU_ADD;
                        md_fam = 1'b1;
                        md_go  = 1'b1;
                        md_op  = (funct == F_MULT) ? MD_MULT : MD_MULTU;
                    end
`ifdef ALU_CTRL_DIV_EN
                    F_DIV, F_DIVU: begin
                        code   = ALU_ADD;
                        md_fam = 1'b1;
                        md_go  = 1'b1;
                        md_op  = (funct == F_DIV) ? MD_DIV : MD_DIVU;
                    end
`endif
                    default: illegal = 1'b1;
                endcase
            end
        endcase
    end

    assign ctrl  = CTRL_W'(code);
    assign stall = valid & md_fam & md_busy;
    assign start = valid & md_go & ~md_busy;

    mdu_core #(.WIDTH(WIDTH)) u_core (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .op     (md_op),
        .a      (a),
        .b      (b),
        .busy   (md_busy),
        .wr_en  (wr_en),
        .res_hi (res_hi),
        .res_lo (res_lo)
    );

    // HI/LO architectural registers and the md_done pulse
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hi      <= '0;
            lo      <= '0;
            md_done <= 1'b0;
        end else begin
            md_done <= wr_en;
            if (wr_en) begin
                hi <= res_hi;
                lo <= res_lo;
            end else if (valid && !md_busy) begin
                if (is_mthi) hi <= a;
                if (is_mtlo) lo <= a;
            end
        end
    end

endmodule

// File: tb/tb_alu_ctrl_mdu.sv
// Directed bench for alu_ctrl_mdu (WIDTH = 32). Divide scenarios are checked
// when ALU_CTRL_DIV_EN is defined; otherwise div/divu are checked as illegal.
module tb_alu_ctrl_mdu;
    import alu_ctrl_pkg::*;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [1:0]   alu_op;
    logic [5:0]   funct;
    logic         valid;
    logic [W-1:0] a, b;
    logic [3:0]   ctrl;
    logic         illegal;
    logic [W-1:0] hi, lo;
    logic         md_busy, md_done, stall;

    int n_tests = 0;
    int n_fail  = 0;

    alu_ctrl_mdu #(.WIDTH(W), .CTRL_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .alu_op(alu_op), .funct(funct), .valid(valid),
        .a(a), .b(b), .ctrl(ctrl), .illegal(illegal), .hi(hi), .lo(lo),
        .md_busy(md_busy), .md_done(md_done), .stall(stall)
    );

    always #5 clk = ~clk;

    // {alu_op, funct, ctrl, illegal}
`ifdef ALU_CTRL_DIV_EN
    localparam logic [12:0] DIV_ROW = {2'b10, 6'b011010, 4'b0010, 1'b0};
`else
    localparam logic [12:0] DIV_ROW = {2'b10, 6'b011010, 4'b0000, 1'b1};
`endif
    localparam logic [12:0] DEC_TBL [20] = '{
        {2'b00, 6'b101010, 4'b0010, 1'b0},
        {2'b01, 6'b111111, 4'b0110, 1'b0},
        {2'b11, 6'b000000, 4'b0001, 1'b0},
        {2'b10, 6'b100000, 4'b0010, 1'b0},
        {2'b10, 6'b100001, 4'b0010, 1'b0},
        {2'b10, 6'b100010, 4'b0110, 1'b0},
        {2'b10, 6'b100011, 4'b0110, 1'b0},
        {2'b10, 6'b100100, 4'b0000, 1'b0},
        {2'b10, 6'b100101, 4'b0001, 1'b0},
        {2'b10, 6'b100110, 4'b0011, 1'b0},
        {2'b10, 6'b100111, 4'b1100, 1'b0},
        {2'b10, 6'b101010, 4'b0111, 1'b0},
        {2'b10, 6'b000000, 4'b1000, 1'b0},
        {2'b10, 6'b000010, 4'b1001, 1'b0},
        {2'b10, 6'b011000, 4'b0010, 1'b0},
        {2'b10, 6'b010000, 4'b0010, 1'b0},
        {2'b10, 6'b010011, 4'b0010, 1'b0},
        {2'b10, 6'b111111, 4'b0000, 1'b1},
        {2'b10, 6'b000001, 4'b0000, 1'b1},
        DIV_ROW
    };

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // present one R-type MDU instruction for a single accepting edge
    task automatic issue(input logic [5:0] f, input logic [W-1:0] x, input logic [W-1:0] y);
        alu_op = 2'b10;
        funct  = f;
        a      = x;
        b      = y;
        valid  = 1'b1;
        tick();
        valid  = 1'b0;
    endtask

    // edges after acceptance until md_done is seen; -1 on timeout
    task automatic wait_done(output int n);
        n = -1;
        for (int i = 1; i <= 200; i++) begin
            tick();
            if (md_done) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; valid = 1'b0; alu_op = 2'b00; funct = 6'd0; a = '0; b = '0;
        tick(); tick();
        n_tests++;
        if (hi !== 32'h0 || lo !== 32'h0 || md_busy !== 1'b0 || md_done !== 1'b0 || stall !== 1'b0) begin
            n_fail++;
            $display("FAIL reset: hi=%h lo=%h busy=%b done=%b stall=%b, want all zero",
                     hi, lo, md_busy, md_done, stall);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_decode();
        logic [12:0] row;
        for (int i = 0; i < 20; i++) begin
            row    = DEC_TBL[i];
            alu_op = row[12:11];
            funct  = row[10:5];
            #1;
            n_tests++;
            if (ctrl !== row[4:1] || illegal !== row[0]) begin
                n_fail++;
                $display("FAIL decode[%0d] op=%b funct=%b: ctrl=%b ill=%b, want ctrl=%b ill=%b",
                         i, row[12:11], row[10:5], ctrl, illegal, row[4:1], row[0]);
            end
        end
    endtask

    task automatic test_mthi_mtlo();
        issue(F_MTHI, 32'hDEADBEEF, 32'h0);
        issue(F_MTLO, 32'h0BADF00D, 32'h0);
        n_tests++;
        if (hi !== 32'hDEADBEEF || lo !== 32'h0BADF00D) begin
            n_fail++;
            $display("FAIL mthi_mtlo: hi=%h lo=%h, want deadbeef 0badf00d", hi, lo);
        end
    endtask

    task automatic test_mult();
        int n;
        alu_op = 2'b10; funct = F_MULT; a = 32'hFFFFFFFE; b = 32'd3; valid = 1'b1;
        #1;
        n_tests++;
        if (stall !== 1'b0) begin
            n_fail++;
            $display("FAIL mult_idle_stall: stall=%b, want 0", stall);
        end
        tick();
        valid = 1'b0;
        n_tests++;
        if (md_busy !== 1'b1 || hi !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL mult_busy: busy=%b hi=%h, want 1 deadbeef", md_busy, hi);
        end
        wait_done(n);
        n_tests++;
        if (n !== 33 || hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFFA) begin
            n_fail++;
            $display("FAIL mult: lat=%0d hi=%h lo=%h, want 33 ffffffff fffffffa", n, hi, lo);
        end
        tick();
        n_tests++;
        if (md_done !== 1'b0 || md_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL mult_pulse: done=%b busy=%b, want 0 0", md_done, md_busy);
        end
    endtask

    task automatic test_multu();
        int n;
        issue(F_MULTU, 32'hFFFFFFFE, 32'd3);
        wait_done(n);
        n_tests++;
        if (n !== 33 || hi !== 32'h00000002 || lo !== 32'hFFFFFFFA) begin
            n_fail++;
            $display("FAIL multu: lat=%0d hi=%h lo=%h, want 33 00000002 fffffffa", n, hi, lo);
        end
    endtask

    task automatic test_div();
`ifdef ALU_CTRL_DIV_EN
        int n;
        issue(F_DIV, 32'hFFFFFFF9, 32'd2);
        wait_done(n);
        n_tests++;
        if (n !== 33 || hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFFD) begin
            n_fail++;
            $display("FAIL div_signed: lat=%0d hi=%h lo=%h, want 33 ffffffff fffffffd", n, hi, lo);
        end
        issue(F_DIV, 32'd7, 32'hFFFFFFFE);
        wait_done(n);
        n_tests++;
        if (hi !== 32'h00000001 || lo !== 32'hFFFFFFFD) begin
            n_fail++;
            $display("FAIL div_negdivisor: hi=%h lo=%h, want 00000001 fffffffd", hi, lo);
        end
        issue(F_DIVU, 32'd100, 32'd7);
        wait_done(n);
        n_tests++;
        if (hi !== 32'd2 || lo !== 32'd14) begin
            n_fail++;
            $display("FAIL divu: hi=%h lo=%h, want 00000002 0000000e", hi, lo);
        end
        issue(F_DIV, 32'h00001234, 32'd0);
        wait_done(n);
        n_tests++;
        if (n !== 1 || hi !== 32'h00001234 || lo !== 32'hFFFFFFFF) begin
            n_fail++;
            $display("FAIL div_zero: lat=%0d hi=%h lo=%h, want 1 00001234 ffffffff", n, hi, lo);
        end
`else
        alu_op = 2'b10; funct = F_DIVU; a = 32'd100; b = 32'd7; valid = 1'b1;
        #1;
        n_tests++;
        if (illegal !== 1'b1 || ctrl !== 4'b0000 || stall !== 1'b0) begin
            n_fail++;
            $display("FAIL divu_disabled: ill=%b ctrl=%b stall=%b, want 1 0000 0", illegal, ctrl, stall);
        end
        tick();
        valid = 1'b0;
        n_tests++;
        if (md_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL div_nostart: busy=%b, want 0", md_busy);
        end
`endif
    endtask

    task automatic test_stall();
        int cnt = 0;
        issue(F_MULT, 32'd5, 32'd7);
        alu_op = 2'b10; funct = F_MFLO; valid = 1'b1;
        #1;
        for (int i = 0; i < 100; i++) begin
            if (!stall) break;
            cnt++;
            tick();
        end
        valid = 1'b0;
        n_tests++;
        if (cnt !== 33 || md_busy !== 1'b0 || lo !== 32'd35) begin
            n_fail++;
            $display("FAIL mflo_stall: stall_cycles=%0d busy=%b lo=%h, want 33 0 00000023", cnt, md_busy, lo);
        end
    endtask

    task automatic test_back_to_back();
        int n;
        issue(F_MULT, 32'd6, 32'hFFFFFFF9);
        wait_done(n);
        alu_op = 2'b10; funct = F_MULTU; a = 32'hFFFFFFFF; b = 32'hFFFFFFFF; valid = 1'b1;
        #1;
        n_tests++;
        if (md_done !== 1'b1 || stall !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_accept: done=%b stall=%b, want 1 0", md_done, stall);
        end
        tick();
        valid = 1'b0;
        n_tests++;
        if (md_busy !== 1'b1 || hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFD6) begin
            n_fail++;
            $display("FAIL b2b_hold: busy=%b hi=%h lo=%h, want 1 ffffffff ffffffd6", md_busy, hi, lo);
        end
        wait_done(n);
        n_tests++;
        if (n !== 33 || hi !== 32'hFFFFFFFE || lo !== 32'h00000001) begin
            n_fail++;
            $display("FAIL b2b_second: lat=%0d hi=%h lo=%h, want 33 fffffffe 00000001", n, hi, lo);
        end
    endtask

    task automatic test_abort();
        int done_seen = 0;
        issue(F_MULT, 32'd123, 32'd456);
        repeat (10) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        n_tests++;
        if (hi !== 32'h0 || lo !== 32'h0 || md_busy !== 1'b0 || md_done !== 1'b0) begin
            n_fail++;
            $display("FAIL abort: hi=%h lo=%h busy=%b done=%b, want 0 0 0 0", hi, lo, md_busy, md_done);
        end
        for (int i = 0; i < 40; i++) begin
            tick();
            if (md_done || md_busy) done_seen++;
        end
        n_tests++;
        if (done_seen !== 0) begin
            n_fail++;
            $display("FAIL abort_quiet: done/busy cycles=%0d, want 0", done_seen);
        end
    endtask

    initial begin
        test_reset();
        test_decode();
        test_mthi_mtlo();
        test_mult();
        test_multu();
        test_div();
        test_stall();
        test_back_to_back();
        test_abort();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
